// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 SRAM access path.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package lc3_mem_pkg;

    // Sequencer states of the SRAM arbiter.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    // Identity of the requester owning the current access.
    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } req_id_t;

    // Strobe-active cycles per SRAM access unless overridden.
    localparam int DEFAULT_WAIT_CYCLES = 2;

endpackage

// File: rtl/mem_wait_timer.sv
// 4-bit loadable down counter timing the strobe-active part of an access.
// Latency: load and decrement take effect at the next rising edge; zero is combinational.
// Backpressure: none; decrement saturates at zero.
module mem_wait_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] count;

    // Count register: synchronous clear, load has priority over decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == 4'd0);

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester (CPU, debug) arbiter and access sequencer for an async SRAM; SRAM_DBG_PORT_EN enables the debug port.
// Latency: request sampled in IDLE at edge t -> one-cycle ack in cycle t+WAIT_CYCLES+1.
// Backpressure: level requests held until ack; requests are only sampled in IDLE, round-robin on ties.
module sram_arbiter
    import lc3_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [19:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ack,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [19:0] dbg_addr,
    input  logic [15:0] dbg_wdata,
    output logic [15:0] dbg_rdata,
    output logic        dbg_ack,
    output logic        CE,
    output logic        UB,
    output logic        LB,
    output logic        OE,
    output logic        WE,
    output logic [19:0] ADDR,
    inout  wire  [15:0] Data
);

    mem_state_t  state, state_nxt;
    req_id_t     grant_q;          // current owner; after an access, the one served last
    req_id_t     sel;
    logic        any_req;
    logic        do_grant;
    logic        tmr_dec;
    logic        tmr_zero;
    logic        we_q;
    logic [19:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] cpu_rdata_q;
    logic        in_access;
    logic        data_oe;

    mem_wait_timer u_timer (
        .clk      (Clk),
        .rst      (Reset),
        .load     (do_grant),
        .load_val (4'(WAIT_CYCLES - 1)),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

`ifdef SRAM_DBG_PORT_EN
    logic [15:0] dbg_rdata_q;

    // Round-robin pick: on a tie, the requester not served last wins.
    always_comb begin
        sel     = REQ_CPU;
        any_req = cpu_req || dbg_req;
        if (cpu_req && dbg_req) begin
            sel = (grant_q == REQ_CPU) ? REQ_DBG : REQ_CPU;
        end else if (dbg_req) begin
            sel = REQ_DBG;
        end
    end

    // Debug read data register, loaded on the last strobe cycle of its reads.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            dbg_rdata_q <= 16'd0;
        end else if (in_access && tmr_zero && !we_q && (grant_q == REQ_DBG)) begin
            dbg_rdata_q <= Data;
        end
    end

    assign dbg_rdata = dbg_rdata_q;
    assign dbg_ack   = (state == DONE) && (grant_q == REQ_DBG);
`else
    logic unused_dbg;

    // CPU is the only requester; debug inputs are discarded.
    always_comb begin
        sel     = REQ_CPU;
        any_req = cpu_req;
    end

    assign unused_dbg = ^{dbg_req, dbg_we, dbg_addr, dbg_wdata};
    assign dbg_rdata  = 16'd0;
    assign dbg_ack    = 1'b0;
`endif

    // Next-state logic: grant in IDLE, hold ACCESS until the timer drains, one DONE cycle.
    always_comb begin
        state_nxt = state;
        do_grant  = 1'b0;
        tmr_dec   = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    do_grant  = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (tmr_zero) begin
                    state_nxt = DONE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, grant and latched request; inputs are captured only at the grant edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            grant_q <= REQ_DBG;
            we_q    <= 1'b0;
            addr_q  <= 20'd0;
            wdata_q <= 16'd0;
        end else begin
            state <= state_nxt;
            if (do_grant) begin
                grant_q <= sel;
                if (sel == REQ_CPU) begin
                    we_q    <= cpu_we;
                    addr_q  <= cpu_addr;
                    wdata_q <= cpu_wdata;
                end else begin
                    we_q    <= dbg_we;
                    addr_q  <= dbg_addr;
                    wdata_q <= dbg_wdata;
                end
            end
        end
    end

    // CPU read data register, loaded on the last strobe cycle of its reads.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cpu_rdata_q <= 16'd0;
        end else if (in_access && tmr_zero && !we_q && (grant_q == REQ_CPU)) begin
            cpu_rdata_q <= Data;
        end
    end

    assign in_access = (state == ACCESS);
    // Write data is held one extra cycle into DONE so it outlasts the WE strobe.
    assign data_oe   = we_q && ((state == ACCESS) || (state == DONE));

    assign CE        = !in_access;
    assign UB        = !in_access;
    assign LB        = !in_access;
    assign OE        = !(in_access && !we_q);
    assign WE        = !(in_access && we_q);
    assign ADDR      = addr_q;
    assign Data      = data_oe ? wdata_q : 16'hzzzz;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = (state == DONE) && (grant_q == REQ_CPU);

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter with a behavioural SRAM and an ack scoreboard.
// Latency: expects ack WAIT_CYCLES+1 cycles after the sampling edge (WAIT_CYCLES=2).
// Backpressure: requests held until ack, dropped in the ack cycle.
module tb_sram_arbiter;

    typedef struct {
        int          who;      // 0 = cpu, 1 = dbg
        bit          is_read;
        logic [15:0] rdata;
    } exp_t;

    logic        Clk;
    logic        Reset;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [19:0] cpu_addr, dbg_addr;
    logic [15:0] cpu_wdata, dbg_wdata;
    logic [15:0] cpu_rdata, dbg_rdata;
    logic        cpu_ack, dbg_ack;
    logic        CE, UB, LB, OE, WE;
    logic [19:0] ADDR;
    wire  [15:0] Data;

    logic [15:0] mem [0:255];
    logic        preload;
    logic        probe;
    logic        sram_drv;
    logic [15:0] sram_val;

    exp_t sb[$];
    int   errors;
    int   checks;

    sram_arbiter #(.WAIT_CYCLES(2)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_rdata (dbg_rdata),
        .dbg_ack   (dbg_ack),
        .CE        (CE),
        .UB        (UB),
        .LB        (LB),
        .OE        (OE),
        .WE        (WE),
        .ADDR      (ADDR),
        .Data      (Data)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // SRAM model: drives read data while selected with OE low; the probe forces 0 so
    // a DUT that is still driving shows up as a non-zero (or contended) value.
    assign sram_drv = probe || (!CE && !OE);
    assign sram_val = probe ? 16'h0000 : mem[ADDR[7:0]];
    assign Data     = sram_drv ? sram_val : 16'hzzzz;

    always @(posedge Clk) begin
        if (preload) begin
            mem[8'h10] <= 16'h1234;
            mem[8'h30] <= 16'hA5A5;
            mem[8'h40] <= 16'h5A5A;
            mem[8'h20] <= 16'h0000;
        end else if (!CE && !WE) begin
            mem[ADDR[7:0]] <= Data;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard: every ack pops one expectation, in order.
    always @(negedge Clk) begin : ack_mon
        exp_t e;
        if (cpu_ack || dbg_ack) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", {30'd0, cpu_ack, dbg_ack}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("ack_who", cpu_ack ? 32'd0 : 32'd1, e.who);
                if (e.is_read)
                    check("ack_rdata", cpu_ack ? cpu_rdata : dbg_rdata, e.rdata);
            end
        end
    end

    task automatic push_exp(input int who, input bit is_read, input logic [15:0] rd);
        exp_t e;
        e.who = who; e.is_read = is_read; e.rdata = rd;
        sb.push_back(e);
    endtask

    task automatic probe_hiz(input string tag);
        probe = 1'b1;
        #1;
        check(tag, Data, 16'h0000);
        probe = 1'b0;
    endtask

    // One CPU access, called right after a negedge in IDLE; returns in the following IDLE cycle.
    task automatic cpu_access(input logic we, input logic [19:0] addr, input logic [15:0] wd,
                              input bit mutate, output int ack_cyc, output int oe_cyc,
                              output int we_cyc, output int data_cyc, output int addr_bad);
        ack_cyc = 0; oe_cyc = 0; we_cyc = 0; data_cyc = 0; addr_bad = 0;
        cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge Clk);
            if (!OE) oe_cyc++;
            if (!WE) we_cyc++;
            if (Data === wd) data_cyc++;
            if (ADDR !== addr) addr_bad++;
            if (mutate && k == 1) begin
                cpu_addr = addr ^ 20'h00070; cpu_we = ~we; cpu_wdata = ~wd;
            end
            if (cpu_ack) begin
                ack_cyc = k;
                break;
            end
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        int ack_cyc, oe_cyc, we_cyc, data_cyc, addr_bad, n;
        errors = 0; checks = 0;
        probe = 1'b0; preload = 1'b1; Reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        repeat (3) @(negedge Clk);
        preload = 1'b0;

        // Reset state
        check("rst_strobes", {CE, UB, LB, OE, WE}, 5'b11111);
        check("rst_addr", ADDR, 20'd0);
        check("rst_acks", {cpu_ack, dbg_ack}, 2'b00);
        check("rst_rdata", {cpu_rdata, dbg_rdata}, 32'd0);
        probe_hiz("rst_data_hiz");
        Reset = 1'b0;
        @(negedge Clk);

        // CPU read of x00010
        push_exp(0, 1, 16'h1234);
        cpu_access(1'b0, 20'h00010, 16'hFFFF, 0, ack_cyc, oe_cyc, we_cyc, data_cyc, addr_bad);
        check("rd_ack_cycle", ack_cyc, 3);
        check("rd_oe_cycles", oe_cyc, 2);
        check("rd_we_cycles", we_cyc, 0);
        check("rd_addr", addr_bad, 0);
        check("rd_rdata_hold", cpu_rdata, 16'h1234);

        // CPU write xBEEF to x00020
        push_exp(0, 0, 16'h0000);
        cpu_access(1'b1, 20'h00020, 16'hBEEF, 0, ack_cyc, oe_cyc, we_cyc, data_cyc, addr_bad);
        check("wr_ack_cycle", ack_cyc, 3);
        check("wr_we_cycles", we_cyc, 2);
        check("wr_oe_cycles", oe_cyc, 0);
        check("wr_data_cycles", data_cyc, 3);
        probe_hiz("wr_data_hiz_after");
        check("wr_mem", mem[8'h20], 16'hBEEF);
        check("wr_rdata_kept", cpu_rdata, 16'h1234);

        // Read with address/we/wdata changed during ACCESS
        push_exp(0, 1, 16'h5A5A);
        cpu_access(1'b0, 20'h00040, 16'hFFFF, 1, ack_cyc, oe_cyc, we_cyc, data_cyc, addr_bad);
        check("stab_ack_cycle", ack_cyc, 3);
        check("stab_addr", addr_bad, 0);
        check("stab_we_cycles", we_cyc, 0);
        check("stab_oe_cycles", oe_cyc, 2);

        // Reset during the second ACCESS cycle of a write
        cpu_we = 1'b1; cpu_addr = 20'h00050; cpu_wdata = 16'h7777; cpu_req = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        check("abort_in_access", {CE, WE}, 2'b00);
        Reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge Clk);
        check("abort_strobes", {CE, UB, LB, OE, WE}, 5'b11111);
        check("abort_ack", {cpu_ack, dbg_ack}, 2'b00);
        check("abort_rdata", cpu_rdata, 16'h0000);
        probe_hiz("abort_data_hiz");
        Reset = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            check("abort_idle_ce", CE, 1'b1);
        end

`ifdef SRAM_DBG_PORT_EN
        // Tie: both requests held, grants must go CPU, dbg, CPU
        push_exp(0, 1, 16'h1234);
        push_exp(1, 1, 16'hA5A5);
        push_exp(0, 1, 16'h1234);
        cpu_we = 0; cpu_addr = 20'h00010; dbg_we = 0; dbg_addr = 20'h00030;
        cpu_req = 1'b1; dbg_req = 1'b1;
        n = 0;
        for (int k = 0; k < 40 && n < 3; k++) begin
            @(negedge Clk);
            if (cpu_ack || dbg_ack) n++;
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        check("tie_acks", n, 3);
        repeat (4) begin
            @(negedge Clk);
            check("tie_no_extra", CE, 1'b1);
        end
        check("tie_dbg_rdata", dbg_rdata, 16'hA5A5);
`else
        // Debug port disabled: dbg_req must produce no SRAM activity
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 20'h00030; dbg_wdata = 16'h1111;
        repeat (6) begin
            @(negedge Clk);
            check("off_ce", CE, 1'b1);
            check("off_dbg_ack", dbg_ack, 1'b0);
        end
        check("off_dbg_rdata", dbg_rdata, 16'h0000);
        push_exp(0, 1, 16'hA5A5);
        cpu_access(1'b0, 20'h00030, 16'hFFFF, 0, ack_cyc, oe_cyc, we_cyc, data_cyc, addr_bad);
        check("off_cpu_ack_cycle", ack_cyc, 3);
        check("off_cpu_oe_cycles", oe_cyc, 2);
        dbg_req = 1'b0;
`endif

        @(negedge Clk);
        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
